// File: rtl/commutation_control.sv
// Six-step commutation decoder with dead-time inserter for a sensored BLDC inverter.
// Ports:
//   clk  - system clock, rising edge
//   rst  - synchronous active-high reset
//   UI   - command {cw, ccw, regen brake}
//   HS   - Hall code {HA, HB, HC}, used without a synchroniser
//   PT   - registered gate enables {AH, AL, BH, BL, CH, CL}, 1 = on
module commutation_control #(
  parameter int unsigned DEAD_CYCLES = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] UI,
  input  logic [2:0] HS,
  output logic [5:0] PT
);

  localparam int unsigned CNT_W = 4;
  localparam int unsigned PT_W  = 6;
  localparam logic [CNT_W-1:0] DEAD_RELOAD = CNT_W'(DEAD_CYCLES - 1);

  typedef enum logic [2:0] {
    MODE_OFF,
    MODE_CCW,
    MODE_CW,
    MODE_REGEN2,
    MODE_REGEN1
  } mode_e;

  mode_e            mode_c;
  logic [2:0]       hall_idx_c;
  logic             hall_vld_c;
  logic [PT_W-1:0]  target_c;

  logic [PT_W-1:0]  pt_q, pt_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Command decode; conflicting codes fall back to off.
  always_comb begin
    mode_c = MODE_OFF;
    unique case (UI)
      3'b010:  mode_c = MODE_CCW;
      3'b100:  mode_c = MODE_CW;
      3'b110:  mode_c = MODE_REGEN2;
      3'b001:  mode_c = MODE_REGEN1;
      default: mode_c = MODE_OFF;
    endcase
  end

  // Hall code to step index 0..5 (S1..S6); 000 and 111 are invalid.
  always_comb begin
    hall_idx_c = 3'd0;
    hall_vld_c = 1'b1;
    unique case (HS)
      3'b100:  hall_idx_c = 3'd0;
      3'b110:  hall_idx_c = 3'd1;
      3'b010:  hall_idx_c = 3'd2;
      3'b011:  hall_idx_c = 3'd3;
      3'b001:  hall_idx_c = 3'd4;
      3'b101:  hall_idx_c = 3'd5;
      default: hall_vld_c = 1'b0;
    endcase
  end

  // Target drive pattern; cw is ccw shifted by three steps (reversed phase current).
  always_comb begin
    target_c = '0;
    if (hall_vld_c) begin
      unique case (mode_c)
        MODE_CCW: begin
          unique case (hall_idx_c)
            3'd0:    target_c = 6'b100100;
            3'd1:    target_c = 6'b100001;
            3'd2:    target_c = 6'b001001;
            3'd3:    target_c = 6'b011000;
            3'd4:    target_c = 6'b010010;
            default: target_c = 6'b000110;
          endcase
        end
        MODE_CW: begin
          unique case (hall_idx_c)
            3'd0:    target_c = 6'b011000;
            3'd1:    target_c = 6'b010010;
            3'd2:    target_c = 6'b000110;
            3'd3:    target_c = 6'b100100;
            3'd4:    target_c = 6'b100001;
            default: target_c = 6'b001001;
          endcase
        end
        MODE_REGEN2: begin
          unique case (hall_idx_c)
            3'd0, 3'd3: target_c = 6'b010100;
            3'd1, 3'd4: target_c = 6'b010001;
            default:    target_c = 6'b000101;
          endcase
        end
        MODE_REGEN1: target_c = 6'b010101;
        default:     target_c = '0;
      endcase
    end
  end

  // Dead-time inserter: any change away from a live pattern passes through all-off.
  always_comb begin
    pt_d  = pt_q;
    cnt_d = cnt_q;
    if (target_c == pt_q) begin
      pt_d  = pt_q;
    end else if (pt_q != '0) begin
      pt_d  = '0;
      cnt_d = DEAD_RELOAD;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CNT_W'(1);
    end else begin
      pt_d  = target_c;
    end
  end

  // Output and dead-counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      pt_q  <= '0;
      cnt_q <= '0;
    end else begin
      pt_q  <= pt_d;
      cnt_q <= cnt_d;
    end
  end

  assign PT = pt_q;

endmodule

// File: tb/tb_commutation_control.sv
// Bench for commutation_control: two instances (dead time 1 and 3) share stimulus;
// a behavioural model predicts each cycle's PT into per-instance queues.
module tb_commutation_control;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] UI;
  logic [2:0] HS;
  logic [5:0] pt1, pt3;

  int total = 0;
  int bad   = 0;

  logic [5:0] q1[$];
  logic [5:0] q3[$];
  logic [5:0] m1_pt, m3_pt;
  logic [3:0] m1_cnt, m3_cnt;

  always #5 clk = ~clk;

  commutation_control #(.DEAD_CYCLES(1)) u_d1 (.clk(clk), .rst(rst), .UI(UI), .HS(HS), .PT(pt1));
  commutation_control #(.DEAD_CYCLES(3)) u_d3 (.clk(clk), .rst(rst), .UI(UI), .HS(HS), .PT(pt3));

  function automatic logic [5:0] ref_target(input logic [2:0] ui, input logic [2:0] hs);
    if (hs == 3'b000 || hs == 3'b111) return 6'b000000;
    case (ui)
      3'b010: case (hs)
        3'b100: return 6'b100100;
        3'b110: return 6'b100001;
        3'b010: return 6'b001001;
        3'b011: return 6'b011000;
        3'b001: return 6'b010010;
        default: return 6'b000110;
      endcase
      3'b100: case (hs)
        3'b100: return 6'b011000;
        3'b110: return 6'b010010;
        3'b010: return 6'b000110;
        3'b011: return 6'b100100;
        3'b001: return 6'b100001;
        default: return 6'b001001;
      endcase
      3'b110: case (hs)
        3'b100, 3'b011: return 6'b010100;
        3'b110, 3'b001: return 6'b010001;
        default: return 6'b000101;
      endcase
      3'b001: return 6'b010101;
      default: return 6'b000000;
    endcase
  endfunction

  function automatic logic [9:0] mstep(input int dead, input logic [5:0] pt, input logic [3:0] cnt,
                                       input logic r, input logic [5:0] tgt);
    logic [5:0] p;
    logic [3:0] c;
    p = pt;
    c = cnt;
    if (r) begin
      p = '0;
      c = '0;
    end else if (tgt == pt) begin
      p = pt;
    end else if (pt != 0) begin
      p = '0;
      c = 4'(dead - 1);
    end else if (cnt != 0) begin
      c = cnt - 4'd1;
    end else begin
      p = tgt;
    end
    return {p, c};
  endfunction

  function automatic bit no_shoot(input logic [5:0] p);
    return !(p[5] & p[4]) && !(p[3] & p[2]) && !(p[1] & p[0]);
  endfunction

  task automatic tick(input int n);
    logic [5:0] tgt, e1, e3;
    for (int i = 0; i < n; i++) begin
      tgt = ref_target(UI, HS);
      {m1_pt, m1_cnt} = mstep(1, m1_pt, m1_cnt, rst, tgt);
      {m3_pt, m3_cnt} = mstep(3, m3_pt, m3_cnt, rst, tgt);
      q1.push_back(m1_pt);
      q3.push_back(m3_pt);
      @(posedge clk);
      #1;
      e1 = q1.pop_front();
      e3 = q3.pop_front();
      total++;
      assert (pt1 === e1) else begin bad++; $error("FAIL sb_d1 observed=%b expected=%b", pt1, e1); end
      total++;
      assert (pt3 === e3) else begin bad++; $error("FAIL sb_d3 observed=%b expected=%b", pt3, e3); end
      total++;
      assert (no_shoot(pt1) && no_shoot(pt3)) else begin
        bad++; $error("FAIL shoot_through observed=%b/%b expected=no leg both on", pt1, pt3);
      end
    end
  endtask

  task automatic check_const(input string tag, input logic [5:0] obs, input logic [5:0] exp);
    total++;
    assert (obs === exp) else begin bad++; $error("FAIL %s observed=%b expected=%b", tag, obs, exp); end
  endtask

  logic [2:0] ccw_hs[6] = '{3'b100, 3'b110, 3'b010, 3'b011, 3'b001, 3'b101};
  logic [5:0] ccw_pt[6] = '{6'b100100, 6'b100001, 6'b001001, 6'b011000, 6'b010010, 6'b000110};
  logic [2:0] cw_hs[6]  = '{3'b101, 3'b001, 3'b011, 3'b010, 3'b110, 3'b100};
  logic [5:0] cw_pt[6]  = '{6'b001001, 6'b100001, 6'b100100, 6'b000110, 6'b010010, 6'b011000};
  logic [2:0] bad_ui[3] = '{3'b111, 3'b101, 3'b011};

  initial begin
    m1_pt = '0; m1_cnt = '0; m3_pt = '0; m3_cnt = '0;
    rst = 1'b1; UI = 3'b010; HS = 3'b100;
    @(negedge clk);
    tick(3);
    check_const("reset_hold", pt1, 6'b000000);
    rst = 1'b0;
    tick(1);
    check_const("reset_release_d1", pt1, 6'b100100);
    check_const("reset_release_d3", pt3, 6'b100100);

    // ccw rotation with explicit one-cycle dead gap on the DEAD_CYCLES=1 instance
    tick(2);
    for (int i = 1; i < 6; i++) begin
      HS = ccw_hs[i];
      tick(1);
      check_const("ccw_dead", pt1, 6'b000000);
      tick(1);
      check_const("ccw_pattern", pt1, ccw_pt[i]);
      tick(1);
    end

    // cw rotation
    UI = 3'b100;
    for (int i = 0; i < 6; i++) begin
      HS = cw_hs[i];
      tick(1);
      check_const("cw_dead", pt1, 6'b000000);
      tick(1);
      check_const("cw_pattern", pt1, cw_pt[i]);
      tick(1);
    end

    // regen-two across all states, then regen-one
    UI = 3'b110;
    for (int i = 0; i < 6; i++) begin
      HS = ccw_hs[i];
      tick(4);
    end
    check_const("regen2_s6", pt1, 6'b000101);
    UI = 3'b001; HS = 3'b100;
    tick(5);
    check_const("regen1", pt1, 6'b010101);
    UI = 3'b100; HS = 3'b101;
    tick(5);
    check_const("cw_s6_pre_brake", pt1, 6'b001001);
    UI = 3'b001;
    tick(1);
    check_const("brake_dead", pt1, 6'b000000);
    tick(1);
    check_const("brake_regen1", pt1, 6'b010101);
    tick(3);

    // conflicting commands and invalid Hall codes
    for (int u = 0; u < 3; u++) begin
      UI = bad_ui[u];
      for (int h = 0; h < 8; h++) begin
        HS = 3'(h);
        tick(2);
        check_const("bad_ui", pt1, 6'b000000);
      end
    end
    UI = 3'b010;
    HS = 3'b000; tick(2); check_const("hs_000", pt1, 6'b000000);
    HS = 3'b111; tick(2); check_const("hs_111", pt1, 6'b000000);

    // dead window of three cycles with two target changes inside it
    HS = 3'b100;
    tick(5);
    check_const("d3_settled", pt3, 6'b100100);
    HS = 3'b110; tick(1); check_const("d3_dead1", pt3, 6'b000000);
    HS = 3'b010; tick(1); check_const("d3_dead2", pt3, 6'b000000);
    HS = 3'b011; tick(1); check_const("d3_dead3", pt3, 6'b000000);
    tick(1);
    check_const("d3_last_target", pt3, 6'b011000);

    // reset inside the dead window
    HS = 3'b001;
    tick(1);
    check_const("d3_dead_pre_rst", pt3, 6'b000000);
    rst = 1'b1;
    tick(1);
    check_const("d3_rst_pt", pt3, 6'b000000);
    total++;
    assert (u_d3.cnt_q === 4'd0) else begin
      bad++; $error("FAIL d3_rst_cnt observed=%0d expected=0", u_d3.cnt_q);
    end
    rst = 1'b0; UI = 3'b000;
    tick(3);
    check_const("d3_no_stale", pt3, 6'b000000);
    UI = 3'b010;
    tick(1);
    check_const("d3_after_rst", pt3, 6'b010010);
    tick(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/commutation_control.md
Name: commutation_control

Overview:
- Six-step commutation decoder for a sensored three-phase BLDC inverter.
- Maps the 3-bit user command (cw / ccw / regenerative brake) and the 3-bit Hall sensor code to six gate-drive enables, one high-side and one low-side per phase.
- Sits between the user/control logic and the gate-driver pins.
- The output is registered and passes through a dead-time inserter so that no phase leg can shoot through.

Parameters:
DEAD_CYCLES, 1, number of clock cycles all gates are held off between two different non-zero drive patterns (legal range 1..15).

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous, active-high reset
UI   input  3  command: UI[2]=cw, UI[1]=ccw, UI[0]=regen brake
HS   input  3  Hall code {HA,HB,HC}, sampled every clock, no internal synchroniser
PT   output 6  gate enables {AH,AL,BH,BL,CH,CL} (PT[5]=AH … PT[0]=CL), 1 = transistor on

Behaviour:
Hall states (HS → state): 100 → S1, 110 → S2, 010 → S3, 011 → S4, 001 → S5, 101 → S6. HS=000 and HS=111 are invalid.

Command decode (UI → mode):
- 000 → off.
- 010 → ccw.
- 100 → cw.
- 110 → regen-two.
- 001 → regen-one.
- All other codes (011, 101, 111) are conflicting and map to off.

Target pattern (combinational), listed S1..S6:
- ccw: 100100, 100001, 001001, 011000, 010010, 000110.
- cw: 011000, 010010, 000110, 100100, 100001, 001001.
- regen-two (low sides of the two phases driven in that state): 010100, 010001, 000101, 010100, 010001, 000101.
- regen-one: 010101 (all low sides) for any valid Hall state.
- off mode, or an invalid Hall code in any mode: 000000.

Invariant: PT[5]&PT[4], PT[3]&PT[2] and PT[1]&PT[0] are never 1, on any cycle, including during dead time.

Output register and dead time (state: PT register, dead counter cnt):
- rst=1 → PT=000000, cnt=0 on the next edge; this has priority over everything and may be asserted mid-operation.
- target == PT → hold.
- target != PT and PT != 0 → PT ← 000000, cnt ← DEAD_CYCLES-1.
- PT == 0 and cnt != 0 → cnt ← cnt-1, PT stays 0.
- PT == 0, cnt == 0 and target != 0 → PT ← target.

Resulting timing:
- Off → pattern: PT updates 1 cycle after the input change.
- Pattern → different pattern: PT=0 for exactly DEAD_CYCLES cycles, then the new target; total latency DEAD_CYCLES+1 cycles.
- Pattern → target 0: PT=0 after 1 cycle.
- Target changes during dead time: the dead time is not restarted; whatever target is current when cnt reaches 0 is loaded.
- Target returns to 0 during dead time: PT stays 0.

Inputs are sampled only at clock edges; glitches shorter than a cycle that miss an edge have no effect.

Test Plan:
- Reset: hold rst=1 with UI=010, HS=100 → PT=000000 throughout; release rst → PT=100100 one cycle later.
- ccw rotation, DEAD_CYCLES=1: UI=010, HS stepped 100,110,010,011,001,101, each held 3 cycles → PT = 100100, 000000, 100001, 000000, 001001 … 000110. Each new pattern appears 2 cycles after the HS change with exactly one all-zero cycle between patterns.
- cw rotation: UI=100, HS stepped 101,001,011,010,110,100 → PT = 001001, 100001, 100100, 000110, 010010, 011000, with dead cycles between.
- Braking: UI=110 across all six states → PT per the regen-two row. UI=001 with any valid HS → PT=010101. Switching from UI=100,HS=101 (001001) to UI=001 → one 000000 cycle, then 010101.
- Illegal inputs: UI=111, 101 or 011 with every HS → PT=000000. HS=000 or 111 with UI=010 → PT=000000. Every cycle of every test checks the no-shoot-through invariant.
- Dead-time edge cases with DEAD_CYCLES=3: change target twice inside the dead window → PT=0 for exactly 3 cycles, then the last target. Assert rst during the dead window → PT=0 and cnt=0, and no stale pattern appears after reset is released.
